// File: rtl/apb_pkg.sv
// Shared APB slave definitions: FSM state type, strobe width helper, wait-state limit.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } apb_slv_state_e;

  localparam int APB_MAX_WAIT = 15;

  // Number of byte lanes on a DATA_W-wide bus.
  function automatic int strb_w(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/bytelane_mem.sv
// Byte-lane RAM: one byte-wide array per lane, per-lane write enable,
// registered read port with enable and synchronous clear.
module bytelane_mem #(
  parameter int LANES = 4,
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic                 clk,
  input  logic                 srst,
  input  logic [LANES-1:0]     we,
  input  logic [AW-1:0]        addr,
  input  logic [8*LANES-1:0]   wdata,
  input  logic                 rd_en,
  input  logic                 rd_clr,
  output logic [8*LANES-1:0]   rdata
);

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] rd_reg;

      // Lane write: contents are never reset.
      always_ff @(posedge clk) begin
        if (we[gi]) mem[addr] <= wdata[8*gi +: 8];
      end

      // Lane read register: cleared by reset or an error read, otherwise holds.
      always_ff @(posedge clk) begin
        if (srst || rd_clr) rd_reg <= 8'h00;
        else if (rd_en)     rd_reg <= mem[addr];
      end

      assign rdata[8*gi +: 8] = rd_reg;
    end
  endgenerate

endmodule

// File: rtl/apb_ram_ws.sv
// Parametrised APB slave RAM with wait states, byte strobes and error response.
// The FSM issues exactly one memory operation and one PREADY pulse per transfer.
module apb_ram_ws
  import apb_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                        PCLK,
  input  logic                        PRESET,
  input  logic [ADDR_W-1:0]           PADDR,
  input  logic                        PWRITE,
  input  logic                        PSEL,
  input  logic                        PENABLE,
  input  logic [DATA_W-1:0]           PWDATA,
  input  logic [strb_w(DATA_W)-1:0]   PSTRB,
  output logic [DATA_W-1:0]           PRDATA,
  output logic                        PREADY,
  output logic                        PSLVERR
);

  localparam int STRB_W = strb_w(DATA_W);
  localparam int OFS    = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_W - OFS;
  localparam int MEM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WAIT_INIT = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  apb_slv_state_e state_reg;
  logic [3:0]     cnt_reg;
  logic           pready_reg;
  logic           pslverr_reg;

  logic             acc;
  logic [IDX_W-1:0] word_idx;
  logic             misalign;
  logic             out_of_range;
  logic             err;
  logic             exec;

  assign acc          = PSEL & PENABLE;
  assign word_idx     = PADDR[ADDR_W-1:OFS];
  assign out_of_range = ({1'b0, word_idx} >= (IDX_W+1)'(DEPTH_WORDS));
  assign err          = out_of_range | misalign;

  // Byte buses have no sub-word offset, so nothing can be misaligned.
  generate
    if (OFS > 0) begin : g_align
      assign misalign = |PADDR[OFS-1:0];
    end else begin : g_no_align
      assign misalign = 1'b0;
    end
  endgenerate

  // Execute strobe: the single cycle in which the memory operation happens.
  always_comb begin
    exec = 1'b0;
    case (state_reg)
      IDLE:    exec = acc && (WAIT_CYCLES == 0);
      WAIT:    exec = acc && (cnt_reg == 4'd0);
      default: exec = 1'b0;
    endcase
    if (PRESET) exec = 1'b0;
  end

  logic [STRB_W-1:0] mem_we;
  logic              mem_rd_en;
  logic              mem_rd_clr;

  assign mem_we     = {STRB_W{exec & PWRITE & ~err}} & PSTRB;
  assign mem_rd_en  = exec & ~PWRITE & ~err;
  assign mem_rd_clr = exec & ~PWRITE & err;

  bytelane_mem #(
    .LANES (STRB_W),
    .DEPTH (DEPTH_WORDS),
    .AW    (MEM_AW)
  ) u_mem (
    .clk    (PCLK),
    .srst   (PRESET),
    .we     (mem_we),
    .addr   (word_idx[MEM_AW-1:0]),
    .wdata  (PWDATA),
    .rd_en  (mem_rd_en),
    .rd_clr (mem_rd_clr),
    .rdata  (PRDATA)
  );

  // Transfer FSM: wait-state counting and registered PREADY/PSLVERR.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_reg   <= IDLE;
      cnt_reg     <= 4'd0;
      pready_reg  <= 1'b0;
      pslverr_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (acc) begin
            if (WAIT_CYCLES == 0) begin
              pready_reg  <= 1'b1;
              pslverr_reg <= err;
              state_reg   <= RESP;
            end else begin
              cnt_reg   <= WAIT_INIT;
              state_reg <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!acc) begin
            state_reg <= IDLE;
          end else if (cnt_reg == 4'd0) begin
            pready_reg  <= 1'b1;
            pslverr_reg <= err;
            state_reg   <= RESP;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        RESP: begin
          // Access still asserted here is the tail of the finished transfer.
          pready_reg  <= 1'b0;
          pslverr_reg <= 1'b0;
          state_reg   <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign PREADY  = pready_reg;
  assign PSLVERR = pslverr_reg;

endmodule

// File: tb/tb_apb_ram_ws.sv
// Self-checking bench: two instances (no wait states / 1024 words, and
// 3 wait states / 512 words) driven by directed and random APB transfers.
module tb_apb_ram_ws;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int SW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [AW-1:0] paddr   [2];
  logic          pwrite  [2];
  logic          psel    [2];
  logic          penable [2];
  logic [DW-1:0] pwdata  [2];
  logic [SW-1:0] pstrb   [2];
  logic [DW-1:0] prdata  [2];
  logic          pready  [2];
  logic          pslverr [2];

  apb_ram_ws #(.ADDR_W(AW), .DATA_W(DW), .DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_d0 (
    .PCLK(clk), .PRESET(rst), .PADDR(paddr[0]), .PWRITE(pwrite[0]), .PSEL(psel[0]),
    .PENABLE(penable[0]), .PWDATA(pwdata[0]), .PSTRB(pstrb[0]), .PRDATA(prdata[0]),
    .PREADY(pready[0]), .PSLVERR(pslverr[0]));

  apb_ram_ws #(.ADDR_W(AW), .DATA_W(DW), .DEPTH_WORDS(512), .WAIT_CYCLES(3)) u_d1 (
    .PCLK(clk), .PRESET(rst), .PADDR(paddr[1]), .PWRITE(pwrite[1]), .PSEL(psel[1]),
    .PENABLE(penable[1]), .PWDATA(pwdata[1]), .PSTRB(pstrb[1]), .PRDATA(prdata[1]),
    .PREADY(pready[1]), .PSLVERR(pslverr[1]));

  int checks = 0;
  int errors = 0;

  // Reference model: word array per instance plus last returned read data.
  logic [DW-1:0] mem_m   [2][1024];
  logic [DW-1:0] last_rd [2];

  function automatic int waits_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic int depth_of(input int d);
    return (d == 0) ? 1024 : 512;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One APB transfer; lat is the access cycle in which PREADY was seen (0 = timeout).
  task automatic xfer(input int d, input bit wr, input logic [AW-1:0] a,
                      input logic [DW-1:0] wd, input logic [SW-1:0] st,
                      output logic [DW-1:0] rd, output logic err, output int lat);
    @(posedge clk); #1;
    psel[d] = 1'b1; penable[d] = 1'b0; paddr[d] = a; pwrite[d] = wr;
    pwdata[d] = wd; pstrb[d] = st;
    @(posedge clk); #1;
    penable[d] = 1'b1;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      if (pready[d] === 1'b1) begin
        lat = n;
        break;
      end
      @(posedge clk); #1;
    end
    rd  = prdata[d];
    err = pslverr[d];
    if (lat != 0) begin
      @(posedge clk); #1;
    end
    psel[d] = 1'b0; penable[d] = 1'b0;
    chk("pready_single_pulse", 64'(pready[d]), 64'd0);
  endtask

  // Transfer checked against the model.
  task automatic do_op(input int d, input bit wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, input logic [SW-1:0] st);
    int            idx;
    bit            e;
    logic [DW-1:0] exp_rd;
    logic [DW-1:0] rd;
    logic          err;
    int            lat;
    idx = int'(a) / 4;
    e   = (idx >= depth_of(d)) || (int'(a) % 4 != 0);
    if (wr) begin
      exp_rd = last_rd[d];
    end else begin
      exp_rd = e ? '0 : mem_m[d][idx];
    end
    xfer(d, wr, a, wd, st, rd, err, lat);
    $display("xfer d%0d %s addr=%03h wdata=%08h strb=%h rdata=%08h err=%0d lat=%0d",
             d, wr ? "WR" : "RD", a, wd, st, rd, err, lat);
    chk("latency", 64'(lat), 64'(2 + waits_of(d)));
    chk("pslverr", 64'(err), 64'(e));
    chk("prdata", 64'(rd), 64'(exp_rd));
    if (wr && !e) begin
      for (int i = 0; i < SW; i++)
        if (st[i]) mem_m[d][idx][8*i +: 8] = wd[8*i +: 8];
    end
    last_rd[d] = exp_rd;
  endtask

  initial begin
    logic [DW-1:0] rd_v;
    logic          err_v;
    int            lat_v;
    int            seen;

    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      psel[d] = 0; penable[d] = 0; paddr[d] = '0; pwrite[d] = 0;
      pwdata[d] = '0; pstrb[d] = '0; last_rd[d] = '0;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Idle after reset.
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        chk("rst_pready", 64'(pready[d]), 64'd0);
        chk("rst_pslverr", 64'(pslverr[d]), 64'd0);
        chk("rst_prdata", 64'(prdata[d]), 64'd0);
      end
    end

    // Known contents for the words exercised below.
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < 16; w++)
        do_op(d, 1'b1, AW'(w * 4), $urandom, 4'hF);

    // Basic write/read and byte strobes, both instances.
    for (int d = 0; d < 2; d++) begin
      do_op(d, 1'b1, 12'h010, 32'hDEADBEEF, 4'hF);
      do_op(d, 1'b0, 12'h010, '0, 4'h0);
      do_op(d, 1'b1, 12'h020, 32'hAABBCCDD, 4'hF);
      do_op(d, 1'b1, 12'h020, 32'h11223344, 4'h5);
      do_op(d, 1'b0, 12'h020, '0, 4'h0);
      chk("strobe_merge", 64'(last_rd[d]), 64'hAA22CC44);
      do_op(d, 1'b1, 12'h024, 32'h55555555, 4'h0);
      do_op(d, 1'b0, 12'h024, '0, 4'h0);
    end

    // Error responses on the 512-word instance.
    do_op(1, 1'b1, 12'h800, 32'hFFFFFFFF, 4'hF);
    do_op(1, 1'b0, 12'h010, '0, 4'h0);
    do_op(1, 1'b0, 12'h802, '0, 4'h0);
    do_op(1, 1'b0, 12'h010, '0, 4'h0);
    do_op(0, 1'b0, 12'h012, '0, 4'h0);

    // Master abort during wait states: no PREADY, no write.
    @(posedge clk); #1;
    psel[1] = 1; penable[1] = 0; paddr[1] = 12'h010; pwrite[1] = 1;
    pwdata[1] = 32'hCAFEF00D; pstrb[1] = 4'hF;
    @(posedge clk); #1 penable[1] = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    psel[1] = 0; penable[1] = 0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (pready[1] !== 1'b0) seen++;
    end
    $display("xfer d1 WR addr=010 aborted in wait");
    chk("abort_no_pready", 64'(seen), 64'd0);
    do_op(1, 1'b0, 12'h010, '0, 4'h0);

    // Reset while in wait states discards the pending write.
    @(posedge clk); #1;
    psel[1] = 1; penable[1] = 0; paddr[1] = 12'h030; pwrite[1] = 1;
    pwdata[1] = 32'h12345678; pstrb[1] = 4'hF;
    @(posedge clk); #1 penable[1] = 1;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; psel[1] = 0; penable[1] = 0;
    $display("xfer d1 WR addr=030 reset in wait");
    chk("midrst_pready", 64'(pready[1]), 64'd0);
    chk("midrst_prdata", 64'(prdata[1]), 64'd0);
    last_rd[0] = '0;
    last_rd[1] = '0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (pready[1] !== 1'b0) seen++;
    end
    chk("midrst_no_pready", 64'(seen), 64'd0);
    do_op(1, 1'b0, 12'h030, '0, 4'h0);

    // Random mixed traffic.
    for (int t = 0; t < 80; t++) begin
      int            d;
      int            r;
      int            w;
      logic [AW-1:0] a;
      d = int'($urandom_range(0, 1));
      r = int'($urandom_range(0, 9));
      w = int'($urandom_range(0, 15));
      if (r < 7)       a = AW'(w * 4);
      else if (r == 7) a = AW'(w * 4 + int'($urandom_range(1, 3)));
      else if (d == 1) a = AW'(int'($urandom_range(512, 1023)) * 4);
      else             a = AW'(w * 4);
      do_op(d, $urandom_range(0, 1) == 1, a, $urandom, SW'($urandom_range(0, 15)));
    end

    // Bounded transfer helper keeps an unused-output sanity path warm.
    xfer(0, 1'b0, 12'h000, '0, 4'h0, rd_v, err_v, lat_v);
    chk("final_read", 64'(rd_v), 64'(mem_m[0][0]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_ram_ws.md
Name: apb_ram_ws

Overview:
Parametrised APB slave RAM. It generalises the team's fixed 4 KB APB RAM with configurable data width, depth and wait states, byte-lane writes (PSTRB), and error response (PSLVERR). It sits on the APB bus behind the bridge/decoder as a data-memory peripheral. A small FSM guarantees exactly one memory operation and one PREADY pulse per transfer.

Parameters:
ADDR_W, 12, width of PADDR (byte address).
DATA_W, 32, data bus width; must be a multiple of 8 (8/16/32/64).
DEPTH_WORDS, 1024, number of DATA_W-wide words implemented; must be ≤ 2**(ADDR_W-OFS).
WAIT_CYCLES, 0, extra wait states inserted before PREADY (0..15).

Ports:
PCLK  in  1  clock; all logic on rising edge.
PRESET  in  1  synchronous, active-high reset.
PADDR  in  ADDR_W  byte address.
PWRITE  in  1  1 = write, 0 = read.
PSEL  in  1  slave select.
PENABLE  in  1  access phase.
PWDATA  in  DATA_W  write data.
PSTRB  in  DATA_W/8  byte-lane write enables.
PRDATA  out  DATA_W  read data, registered.
PREADY  out  1  transfer complete, registered, one-cycle pulse.
PSLVERR  out  1  error, valid only with PREADY.

Behaviour:
- OFS = $clog2(DATA_W/8). Word index = PADDR[ADDR_W-1:OFS].
- Reset (PRESET=1 at a clock edge): state=IDLE, cnt=0, PREADY=0, PSLVERR=0, PRDATA=0. Memory contents are not reset.
- Access condition acc = PSEL & PENABLE.
- IDLE:
  - If acc and WAIT_CYCLES==0: execute the operation, PREADY<=1, go to RESP.
  - If acc and WAIT_CYCLES>0: cnt<=WAIT_CYCLES-1, go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - If !acc (master abort): go to IDLE; no operation, no PREADY.
  - Else if cnt==0: execute the operation, PREADY<=1, go to RESP.
  - Else cnt<=cnt-1.
- RESP: PREADY<=0, PSLVERR<=0, go to IDLE unconditionally. acc still high in this cycle is ignored, so there is no double write.
- Latency: PREADY is high in access cycle 2+WAIT_CYCLES, counting the first PSEL&PENABLE cycle as 1. With WAIT_CYCLES=0 the timing matches the existing APB RAM.
- Execute:
  - err = (word index ≥ DEPTH_WORDS) | (PADDR[OFS-1:0] != 0). For DATA_W=8 there is no alignment check.
  - err=1: PSLVERR<=1, no memory write. A read returns PRDATA<=0.
  - Write, no err: for each lane i with PSTRB[i]=1, mem[idx][8i+:8]<=PWDATA[8i+:8]. Lanes with PSTRB[i]=0 are unchanged. PSTRB=0 is a legal no-op with no error. PRDATA is unchanged.
  - Read, no err: PRDATA<=mem[idx]. PSTRB is ignored.
- PRDATA holds its last value between transfers.
- Reset mid-transfer (in WAIT or RESP): return to IDLE, discard the pending operation, PREADY=0.
- Setup phase (PSEL & !PENABLE) and PSEL=0 cause no state change from IDLE.
- PADDR/PWDATA/PSTRB are sampled at the execute edge; the APB protocol holds them stable.

Decomposition:
- Shared package apb_pkg:
  - typedef enum logic [1:0] {IDLE, WAIT, RESP} apb_slv_state_e.
  - Function strb_w(DATA_W) returning DATA_W/8.
  - Constant APB_MAX_WAIT = 15.
- One sub-module, bytelane_mem: DATA_W/8 byte-wide arrays with per-lane write enable and a registered read port. apb_ram_ws holds the FSM, wait counter, error decode and response registers.

Test Plan:
- Reset then idle, default params: PREADY=0, PSLVERR=0, PRDATA=0 for 5 cycles with PSEL=0.
- WAIT_CYCLES=0: write 0xDEADBEEF to 0x010 with PSTRB=0xF, then read 0x010 → PREADY high in access cycle 2 of each transfer, read PRDATA=0xDEADBEEF, PSLVERR=0, exactly one PREADY pulse per transfer.
- Byte strobes: write 0xAABBCCDD to 0x020 with PSTRB=0xF, then 0x11223344 with PSTRB=0x5; read 0x020 → 0xAA22CC44.
- WAIT_CYCLES=3: read 0x010 → PREADY rises in access cycle 5. Abort: drop PSEL during WAIT → no PREADY, mem unchanged, next transfer normal.
- Errors, DEPTH_WORDS=512: write to 0x800 → PREADY=1, PSLVERR=1, mem unchanged. Read 0x802 (misaligned) → PSLVERR=1, PRDATA=0. A following valid read has PSLVERR=0.
- Reset mid-WAIT (WAIT_CYCLES=3) during a write to 0x030 with 0x12345678: assert PRESET one cycle → state IDLE, a later read of 0x030 returns the prior contents.
